stream_rr_merge: RTL and testbench
==================================

# stream_rr_merge

Round-robin scheduler that shares one 64-bit element output stream between `NUM_IN` producer streams, each terminated by an end-of-stream (EOS) beat. It sits between parallel lowered stream kernels and the `out0`/`out1`/`outCtrl` interface the bench drives. Sequencing:

- A single control token on `inCtrl` starts a run.
- Elements are merged fairly onto `out0`.
- Exactly one EOS flag is emitted on `out1` once every input has ended.
- Completion is signalled on `outCtrl`.

## Interface
- `NUM_IN`, default 2: number of input streams, 2..8.
- `DATA_WIDTH`, default 64: element width.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `inCtrl_valid`  in  1  start token valid.
- `inCtrl_ready`  out  1  start token accepted.
- `in_valid`  in  `NUM_IN`  per-input beat valid.
- `in_ready`  out  `NUM_IN`  per-input beat accepted.
- `in_data`  in  `NUM_IN` x `DATA_WIDTH`  per-input element.
- `in_eos`  in  `NUM_IN`  beat is EOS; its data is ignored.
- `out0_valid`  out  1  merged element valid.
- `out0_ready`  in  1  consumer ready.
- `out0_data`  out  `DATA_WIDTH`  merged element.
- `out1_valid`  out  1  EOS flag valid.
- `out1_ready`  in  1  consumer ready.
- `out1_data`  out  1  EOS flag; always 1 when valid.
- `outCtrl_valid`  out  1  completion token valid.
- `outCtrl_ready`  in  1  completion token accepted.
- `elem_count`  out  32  elements forwarded this run; present only with `STREAM_RR_MERGE_COUNT_EN`.

## Operation
- **Handshakes.** A transfer occurs when valid and ready are both high on a rising edge. Valid, once raised, is held with data stable until the transfer.
- **FSM states.**
  - IDLE: `inCtrl_ready`=1; on `inCtrl_valid`, clear `ended[]` and `ptr`, go to RUN.
  - RUN: arbitrate inputs; when every `ended[]` bit is set and the out0 buffer is empty, go to EOS.
  - EOS: `out1_valid`=1, `out1_data`=1; on `out1_ready`, go to CTRL.
  - CTRL: `outCtrl_valid`=1; on `outCtrl_ready`, go to IDLE.
- **Eligibility.** Input i is eligible when `in_valid[i]` and not `ended[i]`.
- **Grant.** The first eligible index searching from `ptr`+1 upward, wrapping modulo `NUM_IN`. `ptr` updates to the granted index only when a transfer occurs.
- **Per-input ready.** `in_ready[i]` = RUN and grant==i and (buffer empty or `out0_ready`). At most one `in_ready` bit is high per cycle.
- **Non-EOS beat.** Loads the single-entry out0 buffer.
- **EOS beat.** Consumed without forwarding; sets `ended[i]`. Later beats on that input are never readied until the next run.
- **Output buffer.** Full/empty flag plus a data register. Load and drain may occur in the same cycle (full throughput).
- **Other states.** No `in_ready` outside RUN; the `inCtrl` token is ignored outside IDLE.

## Timing
- **Reset values.** State IDLE, buffer empty, `ended`=0, `ptr`=`NUM_IN`-1, count 0. Outputs: `inCtrl_ready`=1; `out0_valid`, `out1_valid`, `outCtrl_valid`=0; `out0_data`=0; `out1_data`=0; `in_ready`=0.
- **Latency.** Input transfer to `out0_valid` is 1 cycle. Sustained rate is one element per cycle with `out0_ready` held high.
- **EOS issue.** `out1_valid` rises the cycle after the last out0 transfer, or the cycle after the final EOS beat if the buffer is already empty.
- **Completion.** `outCtrl_valid` rises the cycle after the out1 transfer. `inCtrl_ready` returns the cycle after the outCtrl transfer.
- **EOS-only run.** If all inputs send EOS with no elements: out0 never fires; out1 follows the last EOS by 1 cycle.
- **Mixed beat types.** A simultaneous EOS on one input and data on another are handled by arbitration order; no beat is dropped.
- **Reset mid-run.** Abandons the run, empties the buffer and returns to IDLE on the next edge. Held beats are not acknowledged.

## Configuration
- **`STREAM_RR_MERGE_COUNT_EN` defined:**
  - 32-bit `elem_count` port is present.
  - Increments per out0 transfer and wraps at 2^32.
  - Cleared on reset and on `inCtrl` acceptance.
  - Holds its final value through EOS and CTRL.
- **Not defined:** the port and the counter are absent; behaviour is otherwise identical.

## Structure
- **Package `stream_rr_merge_pkg`:**
  - State enum (IDLE, RUN, EOS, CTRL).
  - `COUNT_WIDTH`=32.
  - `MAX_NUM_IN`=8.
  - Index width function `$clog2`.
- **Sub-module `rr_arbiter`:** combinational grant from request vector and `ptr`, outputting a one-hot grant and an index. The registered pointer update stays in the top level.

## Test plan
- **Basic merge.** `NUM_IN`=2, start token; in0 sends 1,2 then EOS, in1 sends 10,20 then EOS, all valid every cycle, all readies 1. Expect out0 1,10,2,20 on consecutive cycles, then out1_data=1 once, then outCtrl, and `elem_count`=4.
- **Backpressure.** Same stimulus with `out0_ready` toggled 1/0. Expect the same order, each element exactly once, data stable while stalled, no input dropped.
- **EOS-only run.** Both inputs present only EOS. Expect no out0 transfer, one out1 with data 1, `elem_count`=0.
- **Early end.** in0 ends immediately; in1 sends 5,6,7 then EOS. Expect out0 5,6,7; in0 never readied again.
- **Mid-run reset.** Reset asserted after two elements. Expect the next edge shows IDLE, `inCtrl_ready`=1, all valids 0. A second run then completes normally with count restarting at 0.
- **Fairness under saturation.** `NUM_IN`=3, all inputs continuously valid with 4 elements each. Expect strict rotation 0,1,2,0,1,2,…

Source files
------------

// File: rtl/stream_rr_merge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_rr_merge_pkg : shared types and constants for stream_rr_merge |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package stream_rr_merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EOS  = 2'd2,
    ST_CTRL = 2'd3
  } state_t;

  localparam int COUNT_WIDTH = 32;
  localparam int MAX_NUM_IN  = 8;

  // Index width for an n-entry pointer; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_rr_merge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_rr_merge_if : start/producer/consumer/completion handshakes   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface stream_rr_merge_if #(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = 64
);

  logic                                 inCtrl_valid;
  logic                                 inCtrl_ready;
  logic [NUM_IN-1:0]                    in_valid;
  logic [NUM_IN-1:0]                    in_ready;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    in_data;
  logic [NUM_IN-1:0]                    in_eos;
  logic                                 out0_valid;
  logic                                 out0_ready;
  logic [DATA_WIDTH-1:0]                out0_data;
  logic                                 out1_valid;
  logic                                 out1_ready;
  logic                                 out1_data;
  logic                                 outCtrl_valid;
  logic                                 outCtrl_ready;

  // Environment side: starts runs, produces beats, consumes results.
  modport master (
    output inCtrl_valid, input  inCtrl_ready,
    output in_valid,     input  in_ready,
    output in_data,      output in_eos,
    input  out0_valid,   output out0_ready, input out0_data,
    input  out1_valid,   output out1_ready, input out1_data,
    input  outCtrl_valid, output outCtrl_ready
  );

  // Merge block side.
  modport slave (
    input  inCtrl_valid, output inCtrl_ready,
    input  in_valid,     output in_ready,
    input  in_data,      input  in_eos,
    output out0_valid,   input  out0_ready, output out0_data,
    output out1_valid,   input  out1_ready, output out1_data,
    output outCtrl_valid, input outCtrl_ready
  );

endinterface
`default_nettype wire

// File: rtl/stream_rr_merge_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant starting after ptr      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter
  import stream_rr_merge_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1, ptr+2, ... wrapping, so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_rr_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_rr_merge : round-robin merge of EOS-terminated streams        |
// | Optional element counter: define STREAM_RR_MERGE_COUNT_EN            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stream_rr_merge
  import stream_rr_merge_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  stream_rr_merge_if.slave       bus
`ifdef STREAM_RR_MERGE_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] elem_count
`endif
);

  localparam int                IDX_W    = idx_width(NUM_IN);
  localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(NUM_IN - 1);

  if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("stream_rr_merge: NUM_IN must be within 2..%0d", MAX_NUM_IN);
  end

  state_t                  state;
  logic [NUM_IN-1:0]       ended;
  logic [IDX_W-1:0]        ptr;
  logic                    buf_full;
  logic [DATA_WIDTH-1:0]   buf_data;

  logic [NUM_IN-1:0]       eligible;
  logic [NUM_IN-1:0]       grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_any;
  logic                    take;
  logic                    take_eos;
  logic                    take_data;
  logic                    drain;
  logic [NUM_IN-1:0]       ended_next;
  logic                    buf_full_next;

  assign eligible = bus.in_valid & ~ended;

  rr_arbiter #(
    .N     (NUM_IN),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A beat is taken only when the buffer has room now or is draining this cycle.
  assign take      = (state == ST_RUN) && grant_any && (!buf_full || bus.out0_ready);
  assign take_eos  = take &&  bus.in_eos[grant_idx];
  assign take_data = take && !bus.in_eos[grant_idx];
  assign drain     = buf_full && bus.out0_ready;

  assign ended_next    = ended | (take_eos ? grant : '0);
  assign buf_full_next = take_data | (buf_full & ~drain);

  assign bus.in_ready      = take ? grant : '0;
  assign bus.out0_valid    = buf_full;
  assign bus.out0_data     = buf_data;
  assign bus.inCtrl_ready  = (state == ST_IDLE);
  assign bus.out1_valid    = (state == ST_EOS);
  assign bus.out1_data     = (state == ST_EOS);
  assign bus.outCtrl_valid = (state == ST_CTRL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      ended    <= '0;
      ptr      <= PTR_LAST;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      ended    <= ended_next;
      buf_full <= buf_full_next;
      if (take) begin
        ptr <= grant_idx;
      end
      if (take_data) begin
        buf_data <= bus.in_data[grant_idx];
      end
      unique case (state)
        ST_IDLE: begin
          if (bus.inCtrl_valid) begin
            ended <= '0;
            ptr   <= PTR_LAST;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Look at next-cycle values so out1 rises right after the final transfer.
          if ((&ended_next) && !buf_full_next) begin
            state <= ST_EOS;
          end
        end
        ST_EOS: begin
          if (bus.out1_ready) begin
            state <= ST_CTRL;
          end
        end
        ST_CTRL: begin
          if (bus.outCtrl_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STREAM_RR_MERGE_COUNT_EN
  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (state == ST_IDLE && bus.inCtrl_valid) begin
      count <= '0;
    end else if (drain) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  assign elem_count = count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stream_rr_merge : directed self-checking bench, 2- and 3-input DUTs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_stream_rr_merge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stream_rr_merge_if #(.NUM_IN(2), .DATA_WIDTH(64)) b2 ();
  stream_rr_merge_if #(.NUM_IN(3), .DATA_WIDTH(64)) b3 ();

`ifdef STREAM_RR_MERGE_COUNT_EN
  logic [31:0] cnt2;
  logic [31:0] cnt3;
`endif

  stream_rr_merge #(.NUM_IN(2), .DATA_WIDTH(64)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (b2)
`ifdef STREAM_RR_MERGE_COUNT_EN
    , .elem_count (cnt2)
`endif
  );

  stream_rr_merge #(.NUM_IN(3), .DATA_WIDTH(64)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (b3)
`ifdef STREAM_RR_MERGE_COUNT_EN
    , .elem_count (cnt3)
`endif
  );

  localparam logic [64:0] EOS_BEAT = {1'b1, 64'd0};

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  logic [64:0] seq      [2][3][8];
  int          len      [2][3];
  int          pos      [2][3];
  int          fires    [2][3];
  logic [63:0] got      [2][32];
  int          got_cyc  [2][32];
  int          ngot     [2];
  int          n_out1   [2];
  int          out1_first [2];
  logic        out1_seen  [2];
  int          n_ctrl     [2];
  int          ctrl_first [2];
  int          first_in   [2];
  int          start_cyc  [2];
  logic        start_pending [2];
  logic        bp_mode;
  logic        held_v;
  logic [63:0] held_d;

  function automatic logic [64:0] dbeat(input int v);
    return {1'b0, 64'(v)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [64:0] beat;
    for (int i = 0; i < 2; i++) begin
      beat = (pos[0][i] < len[0][i]) ? seq[0][i][pos[0][i]] : 65'd0;
      b2.in_valid[i] = (pos[0][i] < len[0][i]);
      b2.in_data[i]  = beat[63:0];
      b2.in_eos[i]   = beat[64];
    end
    for (int i = 0; i < 3; i++) begin
      beat = (pos[1][i] < len[1][i]) ? seq[1][i][pos[1][i]] : 65'd0;
      b3.in_valid[i] = (pos[1][i] < len[1][i]);
      b3.in_data[i]  = beat[63:0];
      b3.in_eos[i]   = beat[64];
    end
    b2.inCtrl_valid  = start_pending[0];
    b3.inCtrl_valid  = start_pending[1];
    b2.out0_ready    = bp_mode ? (cyc % 2 == 0) : 1'b1;
    b3.out0_ready    = 1'b1;
    b2.out1_ready    = 1'b1;
    b3.out1_ready    = 1'b1;
    b2.outCtrl_ready = 1'b1;
    b3.outCtrl_ready = 1'b1;
  endtask

  task automatic clear_bench();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        len[d][i] = 0; pos[d][i] = 0; fires[d][i] = 0;
      end
      ngot[d] = 0; n_out1[d] = 0; n_ctrl[d] = 0; out1_seen[d] = 1'b0;
      out1_first[d] = -1; ctrl_first[d] = -1; first_in[d] = -1; start_cyc[d] = -1;
      start_pending[d] = 1'b0;
    end
    bp_mode = 1'b0;
    held_v  = 1'b0;
    held_d  = '0;
  endtask

  // One clock: observe handshakes at the falling edge, advance drivers after the rising edge.
  task automatic cycle();
    bit f2 [2];
    bit f3 [3];
    @(negedge clock);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      f2[i] = b2.in_valid[i] && b2.in_ready[i];
      if (f2[i]) begin
        fires[0][i]++;
        if (first_in[0] < 0) first_in[0] = cyc;
      end
    end
    for (int i = 0; i < 3; i++) begin
      f3[i] = b3.in_valid[i] && b3.in_ready[i];
      if (f3[i]) fires[1][i]++;
    end
    if (held_v) begin
      check_eq("stall_valid", 64'(b2.out0_valid), 64'd1);
      check_eq("stall_data", b2.out0_data, held_d);
    end
    held_v = b2.out0_valid && !b2.out0_ready;
    held_d = b2.out0_data;
    if (b2.out0_valid && b2.out0_ready && ngot[0] < 32) begin
      got[0][ngot[0]] = b2.out0_data; got_cyc[0][ngot[0]] = cyc; ngot[0]++;
    end
    if (b3.out0_valid && b3.out0_ready && ngot[1] < 32) begin
      got[1][ngot[1]] = b3.out0_data; got_cyc[1][ngot[1]] = cyc; ngot[1]++;
    end
    if (b2.out1_valid && b2.out1_ready) begin
      n_out1[0]++; out1_seen[0] = b2.out1_data;
      if (out1_first[0] < 0) out1_first[0] = cyc;
    end
    if (b3.out1_valid && b3.out1_ready) begin
      n_out1[1]++; out1_seen[1] = b3.out1_data;
    end
    if (b2.outCtrl_valid && b2.outCtrl_ready) begin
      n_ctrl[0]++;
      if (ctrl_first[0] < 0) ctrl_first[0] = cyc;
    end
    if (b3.outCtrl_valid && b3.outCtrl_ready) n_ctrl[1]++;
    if (b2.inCtrl_valid && b2.inCtrl_ready) begin
      start_pending[0] = 1'b0; start_cyc[0] = cyc;
    end
    if (b3.inCtrl_valid && b3.inCtrl_ready) begin
      start_pending[1] = 1'b0; start_cyc[1] = cyc;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) if (f2[i]) pos[0][i]++;
    for (int i = 0; i < 3; i++) if (f3[i]) pos[1][i]++;
    drive_inputs();
  endtask

  task automatic run(input int d, input int budget);
    start_pending[d] = 1'b1;
    drive_inputs();
    for (int k = 0; k < budget && n_ctrl[d] == 0; k++) cycle();
    check_eq((d == 0) ? "run2_done" : "run3_done", 64'(n_ctrl[d]), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_inctrl_ready"}, 64'(b2.inCtrl_ready), 64'd1);
    check_eq({tag, "_out0_valid"},   64'(b2.out0_valid), 64'd0);
    check_eq({tag, "_out1_valid"},   64'(b2.out1_valid), 64'd0);
    check_eq({tag, "_outctrl_valid"}, 64'(b2.outCtrl_valid), 64'd0);
    check_eq({tag, "_in_ready"},     64'(b2.in_ready), 64'd0);
  endtask

  task automatic load_basic();
    seq[0][0][0] = dbeat(1);  seq[0][0][1] = dbeat(2);  seq[0][0][2] = EOS_BEAT; len[0][0] = 3;
    seq[0][1][0] = dbeat(10); seq[0][1][1] = dbeat(20); seq[0][1][2] = EOS_BEAT; len[0][1] = 3;
  endtask

  task automatic check_basic_order(input string tag);
    logic [63:0] exp4 [4];
    exp4[0] = 64'd1; exp4[1] = 64'd10; exp4[2] = 64'd2; exp4[3] = 64'd20;
    check_eq({tag, "_n"}, 64'(ngot[0]), 64'd4);
    for (int k = 0; k < 4; k++) check_eq({tag, "_data"}, got[0][k], exp4[k]);
    check_eq({tag, "_out1_n"}, 64'(n_out1[0]), 64'd1);
    check_eq({tag, "_out1_data"}, 64'(out1_seen[0]), 64'd1);
  endtask

  initial begin
    int s;
    clear_bench();
    drive_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset");
    check_eq("reset_out0_data", b2.out0_data, 64'd0);
    check_eq("reset_out1_data", 64'(b2.out1_data), 64'd0);
`ifdef STREAM_RR_MERGE_COUNT_EN
    check_eq("reset_count", 64'(cnt2), 64'd0);
`endif
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic merge with exact cycle placement relative to the start handshake.
    clear_bench(); load_basic();
    run(0, 40);
    s = start_cyc[0];
    check_basic_order("basic");
    for (int k = 0; k < 4; k++) check_eq("basic_cyc", 64'(got_cyc[0][k]), 64'(s + 2 + k));
    check_eq("basic_latency", 64'(got_cyc[0][0] - first_in[0]), 64'd1);
    check_eq("basic_out1_cyc", 64'(out1_first[0]), 64'(s + 7));
    check_eq("basic_ctrl_cyc", 64'(ctrl_first[0]), 64'(s + 8));
    @(negedge clock);
    check_eq("basic_idle_again", 64'(b2.inCtrl_ready), 64'd1);
`ifdef STREAM_RR_MERGE_COUNT_EN
    check_eq("basic_count", 64'(cnt2), 64'd4);
`endif
    @(posedge clock);
    #1;

    // Backpressure: out0_ready alternates, order and stability must hold.
    clear_bench(); load_basic(); bp_mode = 1'b1;
    run(0, 60);
    check_basic_order("bp");
    check_eq("bp_fires0", 64'(fires[0][0]), 64'd3);
    check_eq("bp_fires1", 64'(fires[0][1]), 64'd3);
`ifdef STREAM_RR_MERGE_COUNT_EN
    check_eq("bp_count", 64'(cnt2), 64'd4);
`endif

    // EOS-only run.
    clear_bench();
    seq[0][0][0] = EOS_BEAT; len[0][0] = 1;
    seq[0][1][0] = EOS_BEAT; len[0][1] = 1;
    run(0, 20);
    s = start_cyc[0];
    check_eq("eosonly_n", 64'(ngot[0]), 64'd0);
    check_eq("eosonly_out1_n", 64'(n_out1[0]), 64'd1);
    check_eq("eosonly_out1_data", 64'(out1_seen[0]), 64'd1);
    check_eq("eosonly_out1_cyc", 64'(out1_first[0]), 64'(s + 3));
`ifdef STREAM_RR_MERGE_COUNT_EN
    check_eq("eosonly_count", 64'(cnt2), 64'd0);
`endif

    // Early end: in0 ends first and then offers a stray beat that must never be taken.
    clear_bench();
    seq[0][0][0] = EOS_BEAT; seq[0][0][1] = dbeat(99); len[0][0] = 2;
    seq[0][1][0] = dbeat(5); seq[0][1][1] = dbeat(6); seq[0][1][2] = dbeat(7);
    seq[0][1][3] = EOS_BEAT; len[0][1] = 4;
    run(0, 30);
    check_eq("early_n", 64'(ngot[0]), 64'd3);
    check_eq("early_d0", got[0][0], 64'd5);
    check_eq("early_d1", got[0][1], 64'd6);
    check_eq("early_d2", got[0][2], 64'd7);
    check_eq("early_in0_fires", 64'(fires[0][0]), 64'd1);

    // Mid-run reset after two elements, then a clean second run.
    clear_bench(); load_basic();
    start_pending[0] = 1'b1;
    drive_inputs();
    for (int k = 0; k < 30 && ngot[0] < 2; k++) cycle();
    check_eq("midrst_reached", 64'(ngot[0]), 64'd2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_idle("midrst");
    reset = 1'b0;
    clear_bench(); load_basic();
    drive_inputs();
    @(posedge clock);
    #1;
    run(0, 40);
    check_basic_order("rerun");
`ifdef STREAM_RR_MERGE_COUNT_EN
    check_eq("rerun_count", 64'(cnt2), 64'd4);
`endif

    // Fairness with three saturated inputs.
    clear_bench();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) seq[1][i][j] = dbeat((i + 1) * 256 + j);
      seq[1][i][4] = EOS_BEAT;
      len[1][i] = 5;
    end
    run(1, 60);
    check_eq("fair_n", 64'(ngot[1]), 64'd12);
    for (int k = 0; k < 12; k++)
      check_eq("fair_order", got[1][k], 64'(((k % 3) + 1) * 256 + k / 3));
    check_eq("fair_out1_n", 64'(n_out1[1]), 64'd1);
`ifdef STREAM_RR_MERGE_COUNT_EN
    check_eq("fair_count", 64'(cnt3), 64'd12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
